ks_wide_add_seq: RTL and testbench

- Multi-word add sequencer that time-shares one 16-bit registered Kogge-Stone adder instance to compute NWORDS*16-bit sums.
- Accepts wide operands over a valid/ready handshake.
- Issues one 16-bit slice at a time, least-significant slice first, to the external adder port, chaining the carry out of each slice into the next.
- Returns the assembled sum and final carry over a valid/ready handshake. The block sits between a requesting datapath and the shared adder.

---
 rtl/ks_seq_pkg.sv | 14 +
 rtl/ks_seq_slice_mux.sv | 36 +++
 rtl/ks_wide_add_seq.sv | 169 ++++++++++++++++
 tb/tb_ks_wide_add_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ks_seq_pkg.sv
// Shared definitions for the wide add sequencer: slice width and FSM states.
// Optional subtract mode is enabled with the KS_SEQ_SUB_EN macro.
package ks_seq_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ks_seq_slice_mux.sv
// Selects one WORD_W slice from a packed multi-word vector (combinational).
// With KS_SEQ_SUB_EN defined, an extra inv_i input returns the inverted slice.
module ks_seq_slice_mux
    import ks_seq_pkg::*;
#(
    parameter int NWORDS = 4,
    parameter int IDX_W  = $clog2(NWORDS)
) (
    input  logic [WORD_W*NWORDS-1:0] vec_i,
    input  logic [IDX_W-1:0]         idx_i,
`ifdef KS_SEQ_SUB_EN
    input  logic                     inv_i,
`endif
    output logic [WORD_W-1:0]        slice_o
);

    logic [WORD_W-1:0] raw;

    // Compare against each legal index so a non-power-of-two NWORDS never
    // produces an out-of-range part-select.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx_i == IDX_W'(i)) begin
                raw = vec_i[WORD_W*i +: WORD_W];
            end
        end
    end

`ifdef KS_SEQ_SUB_EN
    assign slice_o = inv_i ? ~raw : raw;
`else
    assign slice_o = raw;
`endif

endmodule

// File: rtl/ks_wide_add_seq.sv
// Chains NWORDS slices through one shared, pipelined 16-bit adder, LSB slice first.
// Optional A-B mode (IN_SUB port) is enabled with the KS_SEQ_SUB_EN macro.
module ks_wide_add_seq
    import ks_seq_pkg::*;
#(
    parameter int NWORDS  = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [WORD_W*NWORDS-1:0] IN_A,
    input  logic [WORD_W*NWORDS-1:0] IN_B,
    input  logic                     IN_CIN,
`ifdef KS_SEQ_SUB_EN
    input  logic                     IN_SUB,
`endif
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [WORD_W*NWORDS-1:0] OUT_SUM,
    output logic                     OUT_COUT,
    output logic [WORD_W-1:0]        ADD_A,
    output logic [WORD_W-1:0]        ADD_B,
    output logic                     ADD_CIN,
    input  logic [WORD_W-1:0]        ADD_SUM,
    input  logic                     ADD_COUT
);

    localparam int DW    = WORD_W * NWORDS;
    localparam int IDX_W = $clog2(NWORDS);
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [DW-1:0]     a_q, a_d;
    logic [DW-1:0]     b_q, b_d;
    logic [DW-1:0]     sum_q, sum_d;
    logic [WORD_W-1:0] a_slice, b_slice;
    logic              issue;
`ifdef KS_SEQ_SUB_EN
    logic              sub_q, sub_d;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
`ifdef KS_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
`ifdef KS_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
`ifdef KS_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d     = IN_A;
                    b_d     = IN_B;
                    idx_d   = '0;
                    state_d = ISSUE;
`ifdef KS_SEQ_SUB_EN
                    // Two's-complement subtract: A + ~B + 1.
                    sub_d   = IN_SUB;
                    carry_d = IN_SUB ? 1'b1 : IN_CIN;
`else
                    carry_d = IN_CIN;
`endif
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    for (int i = 0; i < NWORDS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            sum_d[WORD_W*i +: WORD_W] = ADD_SUM;
                        end
                    end
                    carry_d = ADD_COUT;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    ks_seq_slice_mux #(
        .NWORDS (NWORDS),
        .IDX_W  (IDX_W)
    ) u_mux_a (
        .vec_i   (a_q),
        .idx_i   (idx_q),
`ifdef KS_SEQ_SUB_EN
        .inv_i   (1'b0),
`endif
        .slice_o (a_slice)
    );

    ks_seq_slice_mux #(
        .NWORDS (NWORDS),
        .IDX_W  (IDX_W)
    ) u_mux_b (
        .vec_i   (b_q),
        .idx_i   (idx_q),
`ifdef KS_SEQ_SUB_EN
        .inv_i   (sub_q),
`endif
        .slice_o (b_slice)
    );

    // Adder port is quiet outside the single issue cycle of each slice.
    assign issue     = (state_q == ISSUE);
    assign ADD_A     = issue ? a_slice : '0;
    assign ADD_B     = issue ? b_slice : '0;
    assign ADD_CIN   = issue & carry_q;

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign OUT_SUM   = sum_q;
    assign OUT_COUT  = carry_q;

endmodule

// File: tb/tb_ks_wide_add_seq.sv
// Bench for ks_wide_add_seq: models the shared adder as an ADD_LAT-deep pipeline
// and checks sums, latency and adder-port traffic against plain wide arithmetic.
module tb_ks_wide_add_seq;

    localparam int NW     = 4;
    localparam int LAT    = 2;
    localparam int DW     = 16 * NW;
    localparam int PERIOD = LAT + 1;

    logic          CLK       = 1'b0;
    logic          RST_N     = 1'b0;
    logic          IN_VALID  = 1'b0;
    logic          IN_READY;
    logic [DW-1:0] IN_A      = '0;
    logic [DW-1:0] IN_B      = '0;
    logic          IN_CIN    = 1'b0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [DW-1:0] OUT_SUM;
    logic          OUT_COUT;
    logic [15:0]   ADD_A, ADD_B, ADD_SUM;
    logic          ADD_CIN, ADD_COUT;
`ifdef KS_SEQ_SUB_EN
    logic          IN_SUB    = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // External registered adder: result appears LAT cycles after sampling.
    logic [16:0] pipe [LAT];
    always @(posedge CLK) begin
        pipe[0] <= 17'(ADD_A) + 17'(ADD_B) + 17'(ADD_CIN);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ADD_SUM  = pipe[LAT-1][15:0];
    assign ADD_COUT = pipe[LAT-1][16];

    ks_wide_add_seq #(.NWORDS(NW), .ADD_LAT(LAT)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .IN_CIN    (IN_CIN),
`ifdef KS_SEQ_SUB_EN
        .IN_SUB    (IN_SUB),
`endif
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_SUM   (OUT_SUM),
        .OUT_COUT  (OUT_COUT),
        .ADD_A     (ADD_A),
        .ADD_B     (ADD_B),
        .ADD_CIN   (ADD_CIN),
        .ADD_SUM   (ADD_SUM),
        .ADD_COUT  (ADD_COUT)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; expectations come from (DW+1)-bit arithmetic.
    task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic cin, input logic sub, input int hold, input logic hold_vld);
        logic [DW-1:0] b_eff, mask;
        logic [DW:0]   full, part;
        logic          cin0, ec, stable;
        logic [15:0]   ea, eb;
        int            cyc, bad_cyc, j;
        b_eff = sub ? ~b : b;
        cin0  = sub ? 1'b1 : cin;
        full  = {1'b0, a} + {1'b0, b_eff} + (DW+1)'(cin0);

        @(negedge CLK);
        chk({tag, " in_ready idle"}, IN_READY, 1);
        IN_VALID = 1'b1; IN_A = a; IN_B = b; IN_CIN = cin;
`ifdef KS_SEQ_SUB_EN
        IN_SUB = sub;
`endif
        @(negedge CLK);
        IN_VALID = 1'b0; IN_A = ~a; IN_B = ~b; IN_CIN = ~cin;
`ifdef KS_SEQ_SUB_EN
        IN_SUB = ~sub;
`endif
        cyc = 1; bad_cyc = 0;
        while (OUT_VALID !== 1'b1 && cyc < 200) begin
            ea = '0; eb = '0; ec = 1'b0;
            if ((cyc - 1) % PERIOD == 0 && (cyc - 1) / PERIOD < NW) begin
                j    = (cyc - 1) / PERIOD;
                ea   = a[16*j +: 16];
                eb   = b_eff[16*j +: 16];
                mask = (j == 0) ? '0 : ({DW{1'b1}} >> (DW - 16*j));
                part = {1'b0, a & mask} + {1'b0, b_eff & mask} + (DW+1)'(cin0);
                ec   = part[16*j];
            end
            if (bad_cyc == 0 && {ADD_A, ADD_B, ADD_CIN} !== {ea, eb, ec}) bad_cyc = cyc;
            @(negedge CLK);
            cyc++;
        end
        chk({tag, " latency"}, cyc, NW * PERIOD + 1);
        chk({tag, " sum"}, OUT_SUM, full[DW-1:0]);
        chk({tag, " cout"}, OUT_COUT, full[DW]);
        chk({tag, " adder port first bad cycle"}, bad_cyc, 0);

        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                IN_VALID = hold_vld;
                @(negedge CLK);
                if (OUT_VALID !== 1'b1 || OUT_SUM !== full[DW-1:0] || OUT_COUT !== full[DW] ||
                    IN_READY !== 1'b0 || ADD_A !== 16'h0) stable = 1'b0;
            end
            chk({tag, " hold stable"}, stable, 1);
        end

        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        IN_VALID  = 1'b0;
        chk({tag, " ready/valid after release"}, {IN_READY, OUT_VALID}, 2'b10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ra, rb;
        logic          rc, rs;

        #2;
        chk("reset ready/valid", {IN_READY, OUT_VALID}, 2'b10);
        chk("reset sum/cout", {OUT_SUM, OUT_COUT}, '0);
        chk("reset adder port", {ADD_A, ADD_B, ADD_CIN}, '0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        run_op("carry_into_slice1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b0);
        run_op("all_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, 1'b0);
        run_op("port_slices", 64'h4444_3333_2222_1111, 64'h0004_0003_0002_0001, 1'b0, 1'b0, 0, 1'b0);
        chk("port_slices literal sum", OUT_SUM, 64'h4448_3336_2224_1112);
        run_op("backpressure", 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 5, 1'b1);

        // Abort during the wait phase of slice 2, with a carry and partial sum pending.
        @(negedge CLK);
        IN_VALID = 1'b1; IN_A = 64'h0000_0005_FFFF_0001; IN_B = 64'h0000_0006_0001_0001; IN_CIN = 1'b0;
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (7) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("midrst ready/valid", {IN_READY, OUT_VALID}, 2'b10);
        chk("midrst sum/cout", {OUT_SUM, OUT_COUT}, '0);
        chk("midrst adder port", {ADD_A, ADD_B, ADD_CIN}, '0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_op("after_reset", 64'h1, 64'h1, 1'b0, 1'b0, 0, 1'b0);
        chk("after_reset literal sum", OUT_SUM, 64'h2);

`ifdef KS_SEQ_SUB_EN
        run_op("sub_5_minus_7", 64'h5, 64'h7, 1'b0, 1'b1, 0, 1'b0);
        chk("sub_5_minus_7 literal", {OUT_SUM, OUT_COUT}, {64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        run_op("sub_7_minus_5", 64'h7, 64'h5, 1'b1, 1'b1, 0, 1'b0);
        chk("sub_7_minus_5 literal", {OUT_SUM, OUT_COUT}, {64'h2, 1'b1});
`endif

        for (int n = 0; n < 20; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = ~ra;
            rc = 1'($urandom_range(0, 1));
`ifdef KS_SEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op($sformatf("random%0d", n), ra, rb, rc, rs, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
